// File: rtl/dreg_universal.sv
// Purpose : WIDTH-bit D register (q/nq) with load/shift/rotate modes and an auto parallel-to-serial mode.
// Latency : commands take effect on the next rising edge; serialise emits d[0]..d[WIDTH-1] on sout over WIDTH cycles, then pulses done.
// Backpressure: no ready/valid; en/mode/d are ignored while busy, so callers must wait for done (or busy low) before the next command.
// Optional feature macro: DREG_UNIVERSAL_PARITY_EN adds a registered even-parity output 'parity' (== ^q).

module dreg_universal #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  nq,
    output logic              sout,
    output logic              busy,
    output logic              done
`ifdef DREG_UNIVERSAL_PARITY_EN
    ,
    output logic              parity
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SER  = 1'b1
    } state_t;

    // Counter must hold WIDTH-1; a 1-bit minimum keeps WIDTH=1 legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_SER  = 3'b110;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  q_nxt;
    logic [WIDTH-1:0]  shl_v;
    logic [WIDTH-1:0]  shr_v;
    logic [WIDTH-1:0]  rotl_v;
    logic [WIDTH-1:0]  rotr_v;

    // A single-bit register has no neighbours: shifts just take sin, rotates hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_v  = sin;
            assign shr_v  = sin;
            assign rotl_v = q;
            assign rotr_v = q;
        end else begin : g_wn
            assign shl_v  = {q[WIDTH-2:0], sin};
            assign shr_v  = {sin, q[WIDTH-1:1]};
            assign rotl_v = {q[WIDTH-2:0], q[WIDTH-1]};
            assign rotr_v = {q[0], q[WIDTH-1:1]};
        end
    endgenerate

    assign nq   = ~q;
    assign sout = q[0];
    assign busy = (state == SER);

    // Next register contents; shared by q and the parity register so parity always tracks q.
    always_comb begin
        q_nxt = q;
        case (state)
            IDLE: begin
                if (en) begin
                    case (mode)
                        MODE_HOLD: q_nxt = q;
                        MODE_LOAD: q_nxt = d;
                        MODE_SHL:  q_nxt = shl_v;
                        MODE_SHR:  q_nxt = shr_v;
                        MODE_ROTL: q_nxt = rotl_v;
                        MODE_ROTR: q_nxt = rotr_v;
                        MODE_SER:  q_nxt = d;
                        default:   q_nxt = q;
                    endcase
                end
            end
            SER: begin
                // Right shift exposes the next bit on sout; last bit holds while we leave SER.
                if (cnt != '0) begin
                    q_nxt = shr_v;
                end
            end
            default: q_nxt = q;
        endcase
    end

    // Control FSM and registered outputs; reset overrides everything, including a serialise in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_VAL;
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef DREG_UNIVERSAL_PARITY_EN
            parity <= ^RST_VAL;
`endif
        end else begin
            q    <= q_nxt;
            done <= 1'b0;
`ifdef DREG_UNIVERSAL_PARITY_EN
            parity <= ^q_nxt;
`endif
            case (state)
                IDLE: begin
                    if (en && (mode == MODE_SER)) begin
                        cnt   <= CW'(WIDTH - 1);
                        state <= SER;
                    end
                end
                SER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
